// File: rtl/fir_rescale_decim.sv
// fir_rescale_decim: post-FIR output stage for a multi-channel stream.
// Keeps one valid sample in DECIM and registers a full-precision sum with
// the half-up rounding constant. It then arithmetic-shifts that sum right by
// SHIFT and saturates it to OUT_WIDTH.
// Sticky per-channel saturation flags report any clipped kept sample.
module fir_rescale_decim #(
  parameter int CH_NUM    = 2,
  parameter int IN_WIDTH  = 66,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 17,
  parameter int DECIM     = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                tvalid_i,
  input  logic [CH_NUM-1:0][IN_WIDTH-1:0]     tdata_i,
  output logic                                tvalid_o,
  output logic [CH_NUM-1:0][OUT_WIDTH-1:0]    tdata_o,
  output logic [CH_NUM-1:0]                   sat_o,
  input  logic                                sat_clr_i
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int SUM_W = IN_WIDTH + 1;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  // Representable output range, expressed at sum precision for comparison.
  localparam logic signed [SUM_W-1:0] Q_MAX =
    {{(SUM_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] Q_MIN =
    {{(SUM_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // Half-LSB of the shifted result (2^(SHIFT-1)); all zeros when SHIFT = 0.
  function automatic logic [SUM_W-1:0] rnd_const(input int shift);
    logic [SUM_W-1:0] r;
    for (int i = 0; i < SUM_W; i++) begin
      r[i] = (i == shift - 1);
    end
    return r;
  endfunction

  localparam logic [SUM_W-1:0] RND = rnd_const(SHIFT);

  // Floor-shift a rounded sum and clamp it; MSB of the result flags clipping.
  function automatic logic [OUT_WIDTH:0] sat_round(input logic [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] q;
    logic [OUT_WIDTH:0]      r;
    q = $signed(sum) >>> SHIFT;
    if (q > Q_MAX) begin
      r = {1'b1, OUT_MAX};
    end else if (q < Q_MIN) begin
      r = {1'b1, OUT_MIN};
    end else begin
      r = {1'b0, q[OUT_WIDTH-1:0]};
    end
    return r;
  endfunction

  // Illegal parameter combinations stop elaboration.
  if (DECIM < 1) begin : g_err_decim
    $error("fir_rescale_decim: DECIM must be at least 1");
  end
  if (SHIFT >= IN_WIDTH) begin : g_err_shift
    $error("fir_rescale_decim: SHIFT must be smaller than IN_WIDTH");
  end
  if (OUT_WIDTH > IN_WIDTH - SHIFT) begin : g_err_width
    $error("fir_rescale_decim: OUT_WIDTH must not exceed IN_WIDTH - SHIFT");
  end

  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               keep_s;
  logic                               s1_valid_q, s1_valid_d;
  logic [CH_NUM-1:0][SUM_W-1:0]       sum_q, sum_d;
  logic                               tvalid_q, tvalid_d;
  logic [CH_NUM-1:0][OUT_WIDTH-1:0]   tdata_q, tdata_d;
  logic [CH_NUM-1:0]                  sat_q, sat_d;
  logic [CH_NUM-1:0]                  sat_ev_s;
  logic [OUT_WIDTH:0]                 res_s [CH_NUM];

  // Rescale every channel from the stage-1 sum.
  for (genvar n = 0; n < CH_NUM; n++) begin : g_res
    assign res_s[n] = sat_round(sum_q[n]);
  end

  // Decimation: keep the valid sample seen at count zero, advance on every valid.
  always_comb begin
    keep_s = 1'b0;
    cnt_d  = cnt_q;
    if (tvalid_i) begin
      keep_s = (cnt_q == CNT_ZERO);
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage 1: sign-extend kept samples and add the rounding constant.
  always_comb begin
    s1_valid_d = keep_s;
    sum_d      = sum_q;
    for (int n = 0; n < CH_NUM; n++) begin
      if (keep_s) begin
        sum_d[n] = {tdata_i[n][IN_WIDTH-1], tdata_i[n]} + RND;
      end else begin
        sum_d[n] = sum_q[n];
      end
    end
  end

  // Stage 2: publish the rescaled sample; data holds while nothing leaves.
  always_comb begin
    tvalid_d = s1_valid_q;
    tdata_d  = tdata_q;
    sat_ev_s = {CH_NUM{1'b0}};
    for (int n = 0; n < CH_NUM; n++) begin
      if (s1_valid_q) begin
        tdata_d[n]  = res_s[n][OUT_WIDTH-1:0];
        sat_ev_s[n] = res_s[n][OUT_WIDTH];
      end else begin
        tdata_d[n]  = tdata_q[n];
        sat_ev_s[n] = 1'b0;
      end
    end
  end

  // Sticky flags: a clear drops old flags, but a same-cycle event still sets.
  always_comb begin
    if (sat_clr_i) begin
      sat_d = sat_ev_s;
    end else begin
      sat_d = sat_q | sat_ev_s;
    end
  end

  // State registers; reset drops in-flight samples and restarts decimation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= CNT_ZERO;
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      sat_q      <= {CH_NUM{1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      sat_q      <= sat_d;
    end
  end

  assign tvalid_o = tvalid_q;
  assign tdata_o  = tdata_q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_fir_rescale_decim.sv
// Self-checking bench for fir_rescale_decim: a rescaling/decimating instance
// and a pass-through instance, both compared every cycle against a
// queue-based reference model built from plain arithmetic.
module tb_fir_rescale_decim;

  localparam int A_IW = 32, A_OW = 8,  A_SH = 4, A_DEC = 4;
  localparam int B_IW = 32, B_OW = 32, B_SH = 0, B_DEC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic                  a_vi, a_clr, a_vo;
  logic [1:0][A_IW-1:0]  a_di;
  logic [1:0][A_OW-1:0]  a_do;
  logic [1:0]            a_sat;
  logic                  b_vi, b_clr, b_vo;
  logic [1:0][B_IW-1:0]  b_di;
  logic [1:0][B_OW-1:0]  b_do;
  logic [1:0]            b_sat;

  fir_rescale_decim #(.CH_NUM(2), .IN_WIDTH(A_IW), .OUT_WIDTH(A_OW),
                      .SHIFT(A_SH), .DECIM(A_DEC)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .tvalid_i(a_vi), .tdata_i(a_di),
    .tvalid_o(a_vo), .tdata_o(a_do), .sat_o(a_sat), .sat_clr_i(a_clr));

  fir_rescale_decim #(.CH_NUM(2), .IN_WIDTH(B_IW), .OUT_WIDTH(B_OW),
                      .SHIFT(B_SH), .DECIM(B_DEC)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .tvalid_i(b_vi), .tdata_i(b_di),
    .tvalid_o(b_vo), .tdata_o(b_do), .sat_o(b_sat), .sat_clr_i(b_clr));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference arithmetic: floor((x + 2^(sh-1)) / 2^sh), clamped to ow bits.
  function automatic longint rescale(input longint x, input int sh, input int ow,
                                     output bit sat);
    longint q, mx, mn;
    if (sh == 0) q = x;
    else         q = (x + (longint'(1) <<< (sh - 1))) >>> sh;
    mx  = (longint'(1) <<< (ow - 1)) - 1;
    mn  = -mx - 1;
    sat = 1'b0;
    if (q > mx) begin
      q = mx; sat = 1'b1;
    end else if (q < mn) begin
      q = mn; sat = 1'b1;
    end
    return q;
  endfunction

  typedef struct {
    int     due;
    longint d0;
    longint d1;
    bit     s0;
    bit     s1;
  } exp_t;

  exp_t   a_q[$], b_q[$];
  exp_t   ea, eb;
  int     edge_n = 0;
  int     a_vcnt = 0, b_vcnt = 0;
  bit     m_a_v = 1'b0, m_b_v = 1'b0;
  longint m_a_d[2], m_b_d[2];
  bit [1:0] m_a_sat = 2'b00, m_b_sat = 2'b00, ev;
  bit     chk_en = 1'b0;

  // Reference model: counts valids, schedules kept samples two cycles out.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      a_q.delete(); b_q.delete();
      a_vcnt = 0; b_vcnt = 0;
      m_a_v = 1'b0; m_a_d[0] = 0; m_a_d[1] = 0; m_a_sat = 2'b00;
      m_b_v = 1'b0; m_b_d[0] = 0; m_b_d[1] = 0; m_b_sat = 2'b00;
    end else begin
      m_a_v = 1'b0; ev = 2'b00;
      if (a_q.size() > 0 && a_q[0].due == edge_n) begin
        ea = a_q.pop_front();
        m_a_v = 1'b1; m_a_d[0] = ea.d0; m_a_d[1] = ea.d1; ev = {ea.s1, ea.s0};
      end
      m_a_sat = (a_clr ? 2'b00 : m_a_sat) | ev;
      if (a_vi) begin
        if (a_vcnt % A_DEC == 0) begin
          ea.due = edge_n + 1;
          ea.d0 = rescale(longint'($signed(a_di[0])), A_SH, A_OW, ea.s0);
          ea.d1 = rescale(longint'($signed(a_di[1])), A_SH, A_OW, ea.s1);
          a_q.push_back(ea);
        end
        a_vcnt++;
      end

      m_b_v = 1'b0; ev = 2'b00;
      if (b_q.size() > 0 && b_q[0].due == edge_n) begin
        eb = b_q.pop_front();
        m_b_v = 1'b1; m_b_d[0] = eb.d0; m_b_d[1] = eb.d1; ev = {eb.s1, eb.s0};
      end
      m_b_sat = (b_clr ? 2'b00 : m_b_sat) | ev;
      if (b_vi) begin
        if (b_vcnt % B_DEC == 0) begin
          eb.due = edge_n + 1;
          eb.d0 = rescale(longint'($signed(b_di[0])), B_SH, B_OW, eb.s0);
          eb.d1 = rescale(longint'($signed(b_di[1])), B_SH, B_OW, eb.s1);
          b_q.push_back(eb);
        end
        b_vcnt++;
      end
    end
  end

  longint outq0[$], outq1[$];
  int     b_pulses = 0, b_run = 0, b_maxrun = 0;

  // Per-cycle comparison against the model, plus capture of A outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("a_tvalid", longint'(a_vo), longint'(m_a_v));
      for (int n = 0; n < 2; n++) begin
        check_val($sformatf("a_tdata%0d", n), longint'($signed(a_do[n])), m_a_d[n]);
        check_val($sformatf("b_tdata%0d", n), longint'($signed(b_do[n])), m_b_d[n]);
      end
      check_val("a_sat", longint'(a_sat), longint'(m_a_sat));
      check_val("b_tvalid", longint'(b_vo), longint'(m_b_v));
      check_val("b_sat", longint'(b_sat), longint'(m_b_sat));
    end
    if (a_vo === 1'b1) begin
      outq0.push_back(longint'($signed(a_do[0])));
      outq1.push_back(longint'($signed(a_do[1])));
    end
    if (b_vo === 1'b1) begin
      b_pulses++; b_run++;
      if (b_run > b_maxrun) b_maxrun = b_run;
    end else begin
      b_run = 0;
    end
  end

  task automatic a_drive(input bit v, input longint d0, input longint d1, input bit clr);
    a_vi = v; a_di[0] = d0[31:0]; a_di[1] = d1[31:0]; a_clr = clr;
    @(negedge clk);
  endtask

  task automatic a_idle(input int n);
    repeat (n) a_drive(1'b0, 0, 0, 1'b0);
  endtask

  // One kept sample followed by three discarded fillers (DECIM = 4).
  task automatic a_group(input longint d0, input longint d1);
    a_drive(1'b1, d0, d1, 1'b0);
    repeat (3) a_drive(1'b1, 0, 0, 1'b0);
  endtask

  task automatic b_drive(input bit v, input longint d0, input longint d1);
    b_vi = v; b_di[0] = d0[31:0]; b_di[1] = d1[31:0]; b_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_outs();
    outq0.delete(); outq1.delete();
  endtask

  task automatic chk_out(input string tag, input int idx, input longint e0, input longint e1);
    if (idx < outq0.size()) begin
      check_val({tag, "_ch0"}, outq0[idx], e0);
      check_val({tag, "_ch1"}, outq1[idx], e1);
    end else begin
      check_val({tag, "_missing"}, longint'(outq0.size()), longint'(idx + 1));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; a_idle(1); rst = 1'b0;
  endtask

  function automatic longint rnd_data();
    int unsigned sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return longint'($signed($urandom()));
    else          return longint'($urandom_range(0, 6000)) - 3000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_vi = 1'b0; a_clr = 1'b0; a_di = '0;
    b_vi = 1'b0; b_clr = 1'b0; b_di = '0;
    @(negedge clk);
    chk_en = 1'b1;
    a_idle(2);
    rst = 1'b0;
    a_idle(2);
    check_val("rst_tvalid", longint'(a_vo), 0);
    check_val("rst_tdata", longint'(a_do), 0);
    check_val("rst_sat", longint'(a_sat), 0);

    // Half-up rounding at SHIFT = 4.
    clear_outs();
    a_group(24, -24);
    a_group(-25, 23);
    a_idle(4);
    check_val("round_count", longint'(outq0.size()), 2);
    chk_out("round0", 0, 2, -1);
    chk_out("round1", 1, -2, 1);
    check_val("round_sat", longint'(a_sat), 0);

    // Decimation by 4, contiguous and with random gaps.
    for (int pass = 0; pass < 2; pass++) begin
      clear_outs();
      for (int k = 0; k < 12; k++) begin
        a_drive(1'b1, 16 * k, -16 * k, 1'b0);
        if (pass == 1) a_idle($urandom_range(0, 3));
      end
      a_idle(4);
      check_val($sformatf("decim_count_p%0d", pass), longint'(outq0.size()), 3);
      for (int i = 0; i < 3; i++) chk_out($sformatf("decim_p%0d_%0d", pass, i), i, 4 * i, -4 * i);
    end

    // Saturation, sticky behaviour and clear.
    clear_outs();
    a_group(2048, -2064);
    a_idle(3);
    chk_out("sat_vals", 0, 127, -128);
    check_val("sat_set", longint'(a_sat), 3);
    a_group(16, 16);
    a_idle(3);
    check_val("sat_sticky", longint'(a_sat), 3);
    a_drive(1'b0, 0, 0, 1'b1);
    a_idle(1);
    check_val("sat_clear", longint'(a_sat), 0);
    a_drive(1'b1, 2048, 0, 1'b0);
    a_drive(1'b1, 0, 0, 1'b1);
    a_drive(1'b1, 0, 0, 1'b0);
    a_drive(1'b1, 0, 0, 1'b0);
    a_idle(2);
    check_val("sat_set_wins", longint'(a_sat), 1);

    // Reset one cycle after a kept input drops it.
    clear_outs();
    a_drive(1'b1, 100, 200, 1'b0);
    pulse_reset();
    a_idle(3);
    check_val("rstmid_no_out", longint'(outq0.size()), 0);
    check_val("rstmid_tdata", longint'(a_do), 0);
    check_val("rstmid_sat", longint'(a_sat), 0);
    a_drive(1'b1, 32, -32, 1'b0);
    a_idle(3);
    check_val("rstmid_count", longint'(outq0.size()), 1);
    chk_out("rstmid_first", 0, 2, -2);

    // Counter holds across a long gap; valids 1 and 5 are kept.
    pulse_reset();
    clear_outs();
    a_drive(1'b1, 16, -16, 1'b0);
    a_drive(1'b1, 32, -32, 1'b0);
    a_idle(50);
    for (int k = 3; k <= 5; k++) a_drive(1'b1, 16 * k, -16 * k, 1'b0);
    a_idle(3);
    check_val("hold_count", longint'(outq0.size()), 2);
    chk_out("hold_first", 0, 1, -1);
    chk_out("hold_fifth", 1, 5, -5);

    // Random traffic on the rescaling instance.
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      a_drive(1'($urandom_range(0, 1)), rnd_data(), rnd_data(),
              ($urandom_range(0, 15) == 0));
    end
    a_idle(4);

    // Pass-through instance: 100 back-to-back samples.
    b_pulses = 0; b_maxrun = 0;
    for (int i = 0; i < 100; i++) begin
      b_drive(1'b1, longint'($signed($urandom())), longint'($signed($urandom())));
    end
    repeat (4) b_drive(1'b0, 0, 0);
    check_val("pass_pulses", longint'(b_pulses), 100);
    check_val("pass_run", longint'(b_maxrun), 100);
    check_val("pass_sat", longint'(b_sat), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_rescale_decim.md
Name: fir_rescale_decim

Overview:
Post-FIR output stage for multi-channel, valid-qualified streams. Consumes full-precision filter results and decimates by an integer factor. Each kept sample is rounded (half-up), arithmetically right-shifted and saturated to the output sample width. Sits directly downstream of the FIR filter and feeds narrow sample streams to later DSP or interface blocks. No backpressure.

Parameters:
CH_NUM, 2, number of parallel channels sharing one valid
IN_WIDTH, 66, signed input sample width (full-precision FIR output)
OUT_WIDTH, 16, signed output sample width
SHIFT, 17, right-shift (scaling) applied before saturation; 0 disables rounding
DECIM, 4, decimation factor; 1 passes every sample

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
tvalid_i  input  1  input sample valid, common to all channels
tdata_i  input  CH_NUM x IN_WIDTH (packed, signed)  input samples, channel n in slice [n]
tvalid_o  output  1  output sample valid, one-cycle pulse per kept sample
tdata_o  output  CH_NUM x OUT_WIDTH (packed, signed)  rescaled samples
sat_o  output  CH_NUM  sticky per-channel saturation flag
sat_clr_i  input  1  clears all sat_o bits

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Elaboration errors:
  - DECIM < 1.
  - SHIFT >= IN_WIDTH.
  - OUT_WIDTH > IN_WIDTH - SHIFT.
- Reset values:
  - tvalid_o = 0, tdata_o = 0, sat_o = 0.
  - Decimation counter = 0; internal pipeline valids = 0.
- Decimation:
  - Counter cnt, range 0..DECIM-1, advances only on tvalid_i and wraps DECIM-1 -> 0.
  - A sample is kept when tvalid_i = 1 and cnt = 0. The first valid after reset is always kept.
  - All other valid samples are discarded.
  - Cycles with tvalid_i = 0 do not change cnt.
- Pipeline, 2 stages, identical for every channel:
  - S1: sum = tdata_i[n] + 2^(SHIFT-1), computed at IN_WIDTH+1 bits so it cannot overflow. The constant is 0 when SHIFT = 0. Register s1_valid = keep.
  - S2: q = sum >>> SHIFT (arithmetic, floor). Saturate:
    - q > 2^(OUT_WIDTH-1)-1 -> output max, sat event.
    - q < -2^(OUT_WIDTH-1) -> output min, sat event.
    - Otherwise output q truncated to OUT_WIDTH.
  - S2 registers tdata_o and tvalid_o = s1_valid.
- Latency: kept sample on tvalid_i at cycle T appears with tvalid_o = 1 at cycle T+2.
- Back-to-back: supports a kept sample every cycle (DECIM = 1, continuous tvalid_i).
- Output hold: tdata_o updates only when tvalid_o is asserted and holds its value otherwise. tvalid_o is never high two cycles per kept sample.
- Saturation flags:
  - sat_o[n] sets in the cycle tvalid_o asserts with a saturated channel n.
  - sat_clr_i = 1 clears all bits.
  - If a clear and a new sat event hit the same cycle, set wins for that channel.
  - Discarded samples never set sat_o.
- Reset mid-operation: in-flight samples are dropped, with no tvalid_o after reset. The counter returns to 0, so the first valid after reset is kept.
- Rounding is half toward +infinity. Example with SHIFT = 4: 24 -> 2, -24 -> -1, -25 -> -2.

Test Plan:
(Test config: CH_NUM = 2, IN_WIDTH = 32, OUT_WIDTH = 8, SHIFT = 4, DECIM = 4, unless stated otherwise.)
- Rounding: kept inputs ch0 = 24, ch1 = -24, then ch0 = -25, ch1 = 23 -> tdata_o (2, -1) then (-2, 1), each tvalid_o exactly 2 cycles after its input; sat_o = 0.
- Decimation: 12 consecutive valids carrying values 16*k, k = 0..11 -> exactly 3 tvalid_o pulses with outputs 0, 4, 8. Insert random tvalid_i gaps -> same 3 outputs.
- Saturation and sticky flag: ch0 = 2048 (q = 128) -> 127, ch1 = -2064 (q = -129) -> -128, sat_o = 2'b11. Next kept sample in range -> sat_o stays 2'b11. Pulse sat_clr_i -> 2'b00. Clear in the same cycle as a new ch0 saturation -> sat_o[0] = 1.
- Pass-through at DECIM = 1, SHIFT = 0, OUT_WIDTH = IN_WIDTH: continuous tvalid_i for 100 random samples -> tdata_o equals input delayed 2 cycles, 100 consecutive tvalid_o pulses.
- Reset mid-stream: assert rst_i one cycle after a kept input -> no tvalid_o after reset; tdata_o = 0, sat_o = 0. The next valid input is kept and appears 2 cycles later.
- Counter hold: tvalid_i low for 50 cycles between the 2nd and 3rd valid of a group -> no spurious output; the 5th valid overall is kept.
